// File: rtl/feedback_gate_timer.sv
// Feedback gate timer: drives the select of the registered 2:1 output mux
// (0 = feedback off / in0, 1 = feedback on / in1). Runs one OFF+ON period per
// trigger edge, or back-to-back periods in continuous mode.
module feedback_gate_timer #(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned RUN_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic                 continuous_i,
  input  logic                 trigger_i,
  input  logic [CNT_WIDTH-1:0] t_off_i,
  input  logic [CNT_WIDTH-1:0] t_on_i,
  output logic                 sel_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [RUN_WIDTH-1:0] run_count_o
);

  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);
  localparam logic [RUN_WIDTH-1:0] RunOne = RUN_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StOff, StOn} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] shadow_off_q, shadow_off_d;
  logic [CNT_WIDTH-1:0] shadow_on_q, shadow_on_d;
  logic                 trig_q;
  logic                 sel_q, sel_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [RUN_WIDTH-1:0] run_q, run_d;

  logic                 start;
  logic [CNT_WIDTH-1:0] off_len, on_len;

  // Zero-length phases are stretched to one cycle.
  assign off_len = (t_off_i == '0) ? CntOne : t_off_i;
  assign on_len  = (t_on_i == '0) ? CntOne : t_on_i;
  assign start   = trigger_i & ~trig_q;

  // Next-state: phase sequencing, period accounting and registered outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shadow_off_d = shadow_off_q;
    shadow_on_d  = shadow_on_q;
    run_d        = run_q;
    done_d       = 1'b0;

    if (!enable_i) begin
      // Abort wins over a period completing on the same edge.
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (continuous_i || start) begin
            shadow_off_d = off_len;
            shadow_on_d  = on_len;
            cnt_d        = off_len - CntOne;
            state_d      = StOff;
          end
        end
        StOff: begin
          if (cnt_q == '0) begin
            cnt_d   = shadow_on_q - CntOne;
            state_d = StOn;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
        StOn: begin
          if (cnt_q == '0) begin
            done_d = 1'b1;
            run_d  = run_q + RunOne;
            if (continuous_i) begin
              shadow_off_d = off_len;
              shadow_on_d  = on_len;
              cnt_d        = off_len - CntOne;
              state_d      = StOff;
            end else begin
              state_d = StIdle;
            end
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    sel_d  = (state_d == StOn);
    busy_d = (state_d != StIdle);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      shadow_off_q <= '0;
      shadow_on_q  <= '0;
      trig_q       <= 1'b0;
      sel_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      run_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow_off_q <= shadow_off_d;
      shadow_on_q  <= shadow_on_d;
      trig_q       <= trigger_i;
      sel_q        <= sel_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      run_q        <= run_d;
    end
  end

  assign sel_o       = sel_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign run_count_o = run_q;

endmodule

// File: tb/tb_feedback_gate_timer.sv
// Scoreboard bench for feedback_gate_timer: stimulus pushes the expected
// outputs from a period/elapsed-time model; a monitor pops and compares.
module tb_feedback_gate_timer;

  localparam int unsigned CW = 8;
  localparam int unsigned RW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          continuous = 1'b0;
  logic          trigger = 1'b0;
  logic [CW-1:0] t_off = '0;
  logic [CW-1:0] t_on = '0;
  logic          sel, busy, done;
  logic [RW-1:0] run_count;

  int n_vec = 0;
  int n_err = 0;

  // Expected {sel, busy, done, run_count} after each clock edge.
  logic [RW+2:0] exp_q[$];

  // Reference model: a period is a span of p_off+p_on cycles; t counts
  // cycles elapsed since the period started.
  bit m_running;
  int m_t, m_off, m_on, m_runs;
  bit m_trig_prev, m_done;

  feedback_gate_timer #(
    .CNT_WIDTH(CW),
    .RUN_WIDTH(RW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .enable_i    (enable),
    .continuous_i(continuous),
    .trigger_i   (trigger),
    .t_off_i     (t_off),
    .t_on_i      (t_on),
    .sel_o       (sel),
    .busy_o      (busy),
    .done_o      (done),
    .run_count_o (run_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_running = 0; m_t = 0; m_off = 0; m_on = 0; m_runs = 0;
    m_trig_prev = 0; m_done = 0;
  endtask

  task automatic begin_period(input int toff, input int ton);
    m_running = 1;
    m_t = 0;
    m_off = (toff == 0) ? 1 : toff;
    m_on = (ton == 0) ? 1 : ton;
  endtask

  task automatic model_step(input bit en, input bit cont, input bit trig,
                            input int toff, input int ton);
    bit st;
    st = trig && !m_trig_prev;
    m_trig_prev = trig;
    m_done = 0;
    if (!en) begin
      m_running = 0;
    end else if (!m_running) begin
      if (cont || st) begin_period(toff, ton);
    end else begin
      m_t++;
      if (m_t == m_off + m_on) begin
        m_done = 1;
        m_runs++;
        if (cont) begin_period(toff, ton);
        else m_running = 0;
      end
    end
  endtask

  // Apply one cycle of inputs (caller sits at a negedge), queue the
  // expected post-edge outputs, and move to the next negedge.
  task automatic drive(input bit en, input bit cont, input bit trig,
                       input int toff, input int ton);
    logic [RW-1:0] r;
    bit s;
    enable = en; continuous = cont; trigger = trig;
    t_off = CW'(toff); t_on = CW'(ton);
    model_step(en, cont, trig, toff, ton);
    r = RW'(m_runs);
    s = m_running && (m_t >= m_off);
    exp_q.push_back({s, m_running, m_done, r});
    @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    n_vec++;
    if ({sel, busy, done, run_count} !== '0) begin
      n_err++;
      $display("FAIL %s: got sel=%b busy=%b done=%b run=%0d, want all 0",
               name, sel, busy, done, run_count);
    end
  endtask

  // Monitor: compare DUT outputs just after every edge that has an expectation.
  always begin
    logic [RW+2:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if ({sel, busy, done, run_count} !== e) begin
        n_err++;
        $display("FAIL scoreboard @%0t: got sel=%b busy=%b done=%b run=%0d, want sel=%b busy=%b done=%b run=%0d",
                 $time, sel, busy, done, run_count, e[RW+2], e[RW+1], e[RW], e[RW-1:0]);
      end
    end
  end

  initial begin
    bit rc, re, rt;
    int ro, rn;
    model_reset();

    // Reset held with inputs toggling: everything stays at zero.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      enable = $urandom_range(0, 1); trigger = ~trigger; continuous = $urandom_range(0, 1);
      t_off = 1; t_on = 1;
      check_zero("reset_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Single shot 3/2, trigger held high afterwards: exactly one run.
    drive(1, 0, 0, 3, 2);
    for (int i = 0; i < 12; i++) drive(1, 0, 1, 3, 2);
    drive(1, 0, 0, 3, 2);

    // Continuous 1/1 then 0/0, then let the last period finish.
    for (int i = 0; i < 20; i++) drive(1, 1, 0, 1, 1);
    for (int i = 0; i < 20; i++) drive(1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0);

    // Abort 5 cycles into a long ON phase, then idle a while.
    drive(1, 0, 1, 2, 100);
    for (int i = 0; i < 7; i++) drive(1, 0, 1, 2, 100);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 2, 100);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 2, 100);

    // Shadowing: t_on changes mid-ON; a trigger edge while busy is ignored.
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 2, 4);
    drive(1, 1, 1, 2, 7);
    for (int i = 0; i < 20; i++) drive(1, 1, (i % 3) == 0, 2, 7);
    for (int i = 0; i < 12; i++) drive(1, 0, 0, 2, 7);

    // Asynchronous reset mid-ON: outputs clear without a clock edge.
    drive(1, 0, 1, 1, 50);
    for (int i = 0; i < 6; i++) drive(1, 0, 1, 1, 50);
    rst_n = 1'b0;
    #1;
    check_zero("async_reset_mid_on");
    model_reset();
    @(negedge clk);
    check_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic.
    rc = 0; rt = 0; ro = 2; rn = 3;
    for (int i = 0; i < 3000; i++) begin
      re = ($urandom_range(0, 99) < 97);
      if ($urandom_range(0, 99) < 5) rc = ~rc;
      if ($urandom_range(0, 99) < 20) rt = ~rt;
      if ($urandom_range(0, 99) < 10) ro = $urandom_range(0, 4);
      if ($urandom_range(0, 99) < 10) rn = $urandom_range(0, 4);
      drive(re, rc, rt, ro, rn);
    end

    @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
